bus_timer_device: RTL and testbench
===================================

BUS_TIMER_DEVICE -- requirements
Module: bus_timer_device

Interface
REQ-001 The parameter SHALL be BASE_ADDR, default 32'h40000000, meaning the base of the 32-byte device window.
REQ-002 Port clk SHALL be input, width 1, the single system clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be input, width 1, the asynchronous active-low reset.
REQ-004 Port Device_Read SHALL be input, width 1, the CPU load strobe for the device space.
REQ-005 Port Device_Write SHALL be input, width 1, the CPU store strobe for the device space.
REQ-006 Port MemBus_Address SHALL be input, width 32, the byte address from the CPU.
REQ-007 Port MemBus_Write_Data SHALL be input, width 32, the store data from the CPU.
REQ-008 Port Device_Read_Data SHALL be output, width 32, the load data returned to the CPU.
REQ-009 Port leds SHALL be output, width 8, driven from the LED register.
REQ-010 Port digi SHALL be output, width 12, driven from the 7-segment register.
REQ-011 Port irq SHALL be output, width 1, the timer interrupt request.

Function
REQ-012 hit SHALL be asserted when MemBus_Address[31:5] == BASE_ADDR[31:5]; offset = MemBus_Address[4:2]; address bits [1:0] are ignored.
REQ-013 The register map (offset in bytes) SHALL be:
- 0x00 TH (32b, R/W)
- 0x04 TL (32b, R/W)
- 0x08 TCON[2:0] (R/W): bit0 = enable, bit1 = irq enable, bit2 = irq status
- 0x0C LED[7:0] (R/W)
- 0x10 DIGI[11:0] (R/W)
- 0x14 SYSTICK (32b, read-only)
- 0x18 and 0x1C: unmapped
REQ-014 Reads SHALL be combinational with zero latency: Device_Read_Data = selected register, zero-extended, when Device_Read && hit; otherwise 32'h0.
REQ-015 Reads of unmapped offsets SHALL return 32'h0, and reads SHALL have no side effects.
REQ-016 Writes SHALL take effect at the clk edge where Device_Write && hit; register width is truncated from MemBus_Write_Data[LSBs].
REQ-017 Writes to SYSTICK, unmapped offsets, or with hit low SHALL be ignored.
REQ-018 Simultaneous Device_Read and Device_Write SHALL be legal: the read returns the pre-write value.
REQ-019 SYSTICK SHALL increment by 1 every cycle out of reset and wrap from 32'hFFFFFFFF to 0.
REQ-020 Timer states SHALL be IDLE (TCON[0]=0: TL holds) and COUNT (TCON[0]=1); IDLE->COUNT and COUNT->IDLE occur only via a TCON write.
REQ-021 In COUNT, when TL != 32'hFFFFFFFF, TL SHALL become TL+1.
REQ-022 In COUNT, when TL == 32'hFFFFFFFF, TL SHALL become TH and, if TCON[1]=1, TCON[2] SHALL become 1 (overflow event).
REQ-023 When a CPU write to TL coincides with a count or reload, the CPU write SHALL win; a CPU write to TH in the overflow cycle SHALL NOT affect that cycle's reload (the old TH is loaded).
REQ-024 A TCON write SHALL set bits [1:0] from data; bit2 becomes data[2] AND'd with the old bit2, so software can only clear it.
REQ-025 An overflow event in the same cycle as a TCON write SHALL leave TCON[2]=1, with set taking priority over clear; the enable used for the event is the pre-write TCON[1].
REQ-026 irq SHALL be registered-free combinational: irq = TCON[1] & TCON[2].
REQ-027 leds = LED and digi = DIGI, driven directly from registers.

Reset
REQ-028 When reset is low, TH, TL, TCON, LED, DIGI and SYSTICK SHALL all go to 0 immediately, with no clock required.
REQ-029 While reset is low, leds = 0, digi = 0 and irq = 0; Device_Read_Data still follows REQ-014, so a read returns 0.
REQ-030 Reset asserted mid-count SHALL abandon the count; after release the timer is in IDLE with TL = 0, and the first SYSTICK increment occurs at the first rising edge after release.

Verification
REQ-031 Write TH=32'hFFFFFFFC, TL=32'hFFFFFFFE, TCON=3'b011 -> TL reads FFFFFFFF, then FFFFFFFC, TCON reads 3'b111, and irq=1 in the cycle after the wrap.
REQ-032 With irq=1, write TCON=3'b011 -> TCON[2]=0 and irq=0 next cycle; a separate write with data[2]=1 while status=0 -> status stays 0.
REQ-033 In the overflow cycle, write TCON=3'b011 (clear) -> TCON reads 3'b111, showing set priority; in the overflow cycle, write TL=32'h5 -> TL reads 5.
REQ-034 Write LED=32'h1A5 and DIGI=32'hFABC -> leds=8'hA5 and digi=12'hABC; read 0x18 -> 0; write SYSTICK -> no change, SYSTICK keeps incrementing.
REQ-035 Read with MemBus_Address=32'h40000020 or Device_Read=0 -> Device_Read_Data=0; read 0x40000006 -> TL value (bits [1:0] ignored).
REQ-036 Pull reset low between clock edges while counting -> all registers and outputs are 0 before the next edge; after release, SYSTICK reads 1 after the first edge.

Source files
------------

// File: rtl/bus_timer_device.sv
// Memory-mapped timer, LED and 7-segment device with a free-running tick counter.
// Zero-latency reads, single-cycle writes, software-clearable overflow status.
module bus_timer_device #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Device_Read,
  input  logic        Device_Write,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic [7:0]  leds,
  output logic [11:0] digi,
  output logic        irq
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } tstate_e;

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_LED  = 3'd3;
  localparam logic [2:0] OFF_DIGI = 3'd4;
  localparam logic [2:0] OFF_TICK = 3'd5;

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;
  logic [31:0] tick_q, tick_d;

  logic        hit;
  logic [2:0]  off;
  logic        wr;
  logic        ovf;
  tstate_e     state;
  logic        unused_addr_lsb;

  assign hit   = MemBus_Address[31:5] == BASE_ADDR[31:5];
  assign off   = MemBus_Address[4:2];
  assign wr    = Device_Write && hit;
  assign state = tstate_e'(tcon_q[0]);
  assign ovf   = (state == COUNT) && (tl_q == 32'hFFFFFFFF);
  assign unused_addr_lsb = &{1'b0, MemBus_Address[1:0]};

  // Combinational read mux; returns pre-write values.
  always_comb begin
    Device_Read_Data = 32'h0;
    if (Device_Read && hit) begin
      unique case (off)
        OFF_TH:   Device_Read_Data = th_q;
        OFF_TL:   Device_Read_Data = tl_q;
        OFF_TCON: Device_Read_Data = {29'h0, tcon_q};
        OFF_LED:  Device_Read_Data = {24'h0, led_q};
        OFF_DIGI: Device_Read_Data = {20'h0, digi_q};
        OFF_TICK: Device_Read_Data = tick_q;
        default:  Device_Read_Data = 32'h0;
      endcase
    end
  end

  // Next-state: counting, reload, CPU writes (CPU wins on TL, set wins on status).
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    digi_d = digi_q;
    tick_d = tick_q + 32'd1;

    unique case (state)
      IDLE:  tl_d = tl_q;
      COUNT: tl_d = ovf ? th_q : tl_q + 32'd1;
      default: tl_d = tl_q;
    endcase

    if (wr) begin
      unique case (off)
        OFF_TH:   th_d   = MemBus_Write_Data;
        OFF_TL:   tl_d   = MemBus_Write_Data;
        OFF_TCON: tcon_d = {MemBus_Write_Data[2] & tcon_q[2],
                            MemBus_Write_Data[1:0]};
        OFF_LED:  led_d  = MemBus_Write_Data[7:0];
        OFF_DIGI: digi_d = MemBus_Write_Data[11:0];
        default:  ;
      endcase
    end

    if (ovf && tcon_q[1]) tcon_d[2] = 1'b1;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'h0;
      led_q  <= 8'h0;
      digi_q <= 12'h0;
      tick_q <= 32'h0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      tick_q <= tick_d;
    end
  end

  assign leds = led_q;
  assign digi = digi_q;
  assign irq  = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_bus_timer_device.sv
// Scoreboard bench for bus_timer_device.
// Expected read data is queued on drive and popped on return.
module tb_bus_timer_device;

  localparam logic [31:0] B = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Device_Read = 1'b0;
  logic        Device_Write = 1'b0;
  logic [31:0] MemBus_Address = 32'h0;
  logic [31:0] MemBus_Write_Data = 32'h0;
  logic [31:0] Device_Read_Data;
  logic [7:0]  leds;
  logic [11:0] digi;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ticks = 32'h0;

  bus_timer_device #(.BASE_ADDR(B)) dut (
    .clk(clk),
    .reset(reset),
    .Device_Read(Device_Read),
    .Device_Write(Device_Write),
    .MemBus_Address(MemBus_Address),
    .MemBus_Write_Data(MemBus_Write_Data),
    .Device_Read_Data(Device_Read_Data),
    .leds(leds),
    .digi(digi),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) ticks <= 32'h0;
    else ticks <= ticks + 32'd1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemBus_Address = a;
    MemBus_Write_Data = d;
    Device_Write = 1'b1;
    step();
    Device_Write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a,
                    input logic re, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    MemBus_Address = a;
    Device_Read = re;
    #1;
    e = exp_q.pop_front();
    chk(tag, Device_Read_Data, e);
    Device_Read = 1'b0;
  endtask

  initial begin
    #1;
    rd("rst_tl", B + 32'h4, 1'b1, 32'h0);
    chk("rst_leds", {24'h0, leds}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    rd("tick1", B + 32'h14, 1'b1, 32'h1);

    wr(B + 32'h0, 32'hFFFFFFFC);
    wr(B + 32'h4, 32'hFFFFFFFE);
    wr(B + 32'h8, 32'h3);
    rd("tl_start", B + 32'h4, 1'b1, 32'hFFFFFFFE);
    step();
    rd("tl_max", B + 32'h4, 1'b1, 32'hFFFFFFFF);
    chk("irq_pre", {31'h0, irq}, 32'h0);
    step();
    rd("tl_reload", B + 32'h4, 1'b1, 32'hFFFFFFFC);
    rd("tcon_ovf", B + 32'h8, 1'b1, 32'h7);
    chk("irq_set", {31'h0, irq}, 32'h1);

    wr(B + 32'h8, 32'h3);
    rd("tcon_clr", B + 32'h8, 1'b1, 32'h3);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    wr(B + 32'h8, 32'h7);
    rd("tcon_noset", B + 32'h8, 1'b1, 32'h3);
    rd("tl_fe", B + 32'h4, 1'b1, 32'hFFFFFFFE);
    step();
    wr(B + 32'h8, 32'h3);
    rd("tcon_setwin", B + 32'h8, 1'b1, 32'h7);
    rd("tl_reload2", B + 32'h4, 1'b1, 32'hFFFFFFFC);

    wr(B + 32'h8, 32'h3);
    wr(B + 32'h4, 32'hFFFFFFFF);
    wr(B + 32'h4, 32'h5);
    rd("tl_cpuwin", B + 32'h4, 1'b1, 32'h5);

    wr(B + 32'h8, 32'h3);
    wr(B + 32'h4, 32'hFFFFFFFF);
    wr(B + 32'h0, 32'h1234);
    rd("tl_oldth", B + 32'h4, 1'b1, 32'hFFFFFFFC);
    rd("th_new", B + 32'h0, 1'b1, 32'h1234);
    wr(B + 32'h8, 32'h0);
    rd("tl_idle0", B + 32'h4, 1'b1, 32'hFFFFFFFD);
    step();
    rd("tl_idle1", B + 32'h4, 1'b1, 32'hFFFFFFFD);

    wr(B + 32'hC, 32'h1A5);
    wr(B + 32'h10, 32'hFABC);
    chk("leds", {24'h0, leds}, 32'hA5);
    chk("digi", {20'h0, digi}, 32'hABC);
    rd("led_rd", B + 32'hC, 1'b1, 32'hA5);
    rd("unmapped", B + 32'h18, 1'b1, 32'h0);
    wr(B + 32'h14, 32'h0);
    rd("tick_ro", B + 32'h14, 1'b1, ticks);
    step();
    rd("tick_inc", B + 32'h14, 1'b1, ticks);

    rd("miss", B + 32'h20, 1'b1, 32'h0);
    rd("no_rd", B + 32'h4, 1'b0, 32'h0);
    rd("lsb_ign", B + 32'h6, 1'b1, 32'hFFFFFFFD);
    wr(B + 32'h24, 32'h0);
    rd("miss_wr", B + 32'h4, 1'b1, 32'hFFFFFFFD);

    wr(B + 32'h4, 32'h10);
    wr(B + 32'h8, 32'h3);
    step();
    rd("tl_cnt", B + 32'h4, 1'b1, 32'h11);
    reset = 1'b0;
    #1;
    chk("ar_leds", {24'h0, leds}, 32'h0);
    chk("ar_digi", {20'h0, digi}, 32'h0);
    chk("ar_irq", {31'h0, irq}, 32'h0);
    rd("ar_tl", B + 32'h4, 1'b1, 32'h0);
    rd("ar_tcon", B + 32'h8, 1'b1, 32'h0);
    rd("ar_th", B + 32'h0, 1'b1, 32'h0);
    rd("ar_tick", B + 32'h14, 1'b1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    rd("rel_tick", B + 32'h14, 1'b1, 32'h1);
    step();
    rd("rel_tl", B + 32'h4, 1'b1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
